// File: rtl/lynx48_ps2_pkg.sv
// Shared types and helpers for the Lynx48 PS/2 device-side transmitter.
package lynx48_ps2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    GAP  = 2'd3
  } ps2_state_t;

  localparam int FRAME_BITS = 11;

  // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

  // Frame image sent LSB-first: start, data[0..7], parity, stop.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data);
    return {1'b1, odd_parity(data), data, 1'b0};
  endfunction

endpackage

// File: rtl/lynx48_ps2_fifo.sv
// Scancode buffer: single-clock FIFO with registered occupancy count.
module lynx48_ps2_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage array is written only on an accepted push; contents need no reset.
  always_ff @(posedge clk_sys) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lynx48_ps2_dev_tx.sv
// PS/2 device-to-host transmitter: buffers scancodes and clocks them out as 11-bit frames.
module lynx48_ps2_dev_tx
  import lynx48_ps2_pkg::*;
#(
  parameter int CLK_DIV    = 1103,
  parameter int GAP_DIV    = 4412,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       inhibit,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic       overflow
);

  localparam int DIV_MAX = (CLK_DIV > GAP_DIV) ? CLK_DIV : GAP_DIV;
  localparam int DIV_W   = $clog2(DIV_MAX);
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

  ps2_state_t            state;
  logic [DIV_W-1:0]      div_cnt;
  logic [3:0]            bit_cnt;
  logic [FRAME_BITS-1:0] shift;
  logic [FRAME_BITS-1:0] head_frame;
  logic [7:0]            fifo_head;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_pop;
  logic                  clk_done;
  logic                  gap_done;
  logic                  abort;

  lynx48_ps2_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .push      (in_valid),
    .push_data (in_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign in_ready   = !fifo_full;
  assign busy       = (state != IDLE);
  assign head_frame = build_frame(fifo_head);
  assign clk_done   = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign gap_done   = (div_cnt == DIV_W'(GAP_DIV - 1));
  assign abort      = inhibit && (bit_cnt < LAST_BIT);

  // The head byte leaves the FIFO only once its stop bit has been fully clocked.
  always_comb begin
    fifo_pop = 1'b0;
    if (state == LOW && !abort && clk_done && bit_cnt == LAST_BIT && !fifo_empty) begin
      fifo_pop = 1'b1;
    end
  end

  // Transmit FSM with divider, shifter and registered line drivers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      shift    <= '1;
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (in_valid && !in_ready) begin
        overflow <= 1'b1;
      end
      case (state)
        IDLE: begin
          ps2_clk  <= 1'b1;
          ps2_data <= 1'b1;
          if (fifo_count != '0 && !inhibit) begin
            shift    <= head_frame;
            bit_cnt  <= '0;
            div_cnt  <= '0;
            ps2_data <= head_frame[0];
            state    <= HIGH;
          end
        end
        HIGH: begin
          if (abort) begin
            ps2_clk  <= 1'b1;
            ps2_data <= 1'b1;
            div_cnt  <= '0;
            state    <= GAP;
          end else if (clk_done) begin
            ps2_clk <= 1'b0;
            div_cnt <= '0;
            state   <= LOW;
          end else begin
            ps2_data <= shift[0];
            div_cnt  <= div_cnt + DIV_W'(1);
          end
        end
        LOW: begin
          if (abort) begin
            ps2_clk  <= 1'b1;
            ps2_data <= 1'b1;
            div_cnt  <= '0;
            state    <= GAP;
          end else if (clk_done) begin
            shift   <= {1'b1, shift[FRAME_BITS-1:1]};
            bit_cnt <= bit_cnt + 4'd1;
            div_cnt <= '0;
            ps2_clk <= 1'b1;
            if (bit_cnt == LAST_BIT) begin
              ps2_data <= 1'b1;
              state    <= GAP;
            end else begin
              ps2_data <= shift[1];
              state    <= HIGH;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        GAP: begin
          ps2_clk  <= 1'b1;
          ps2_data <= 1'b1;
          if (gap_done) begin
            div_cnt <= '0;
            state   <= IDLE;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lynx48_ps2_dev_tx.sv
// Self-checking bench for lynx48_ps2_dev_tx: scoreboard of pushed bytes vs. decoded PS/2 frames.
module tb_lynx48_ps2_dev_tx;

  localparam int CLK_DIV    = 4;
  localparam int GAP_DIV    = 8;
  localparam int FIFO_DEPTH = 8;

  logic       clk_sys  = 1'b0;
  logic       reset    = 1'b1;
  logic [7:0] in_data  = 8'h00;
  logic       in_valid = 1'b0;
  logic       inhibit  = 1'b0;
  logic       in_ready;
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_q [$];
  int          frames_done = 0;
  int          mon_bit_idx = 0;
  int          hi_run = 1000;
  int          lo_run = 0;
  logic        prev_clk = 1'b1;
  logic        low_data = 1'b1;
  logic [10:0] mon_bits = '0;
  logic [10:0] last_frame = '0;

  lynx48_ps2_dev_tx #(
    .CLK_DIV    (CLK_DIV),
    .GAP_DIV    (GAP_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .inhibit  (inhibit),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .busy     (busy),
    .overflow (overflow)
  );

  // Free-running system clock.
  always #5 clk_sys = ~clk_sys;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    if (in_ready) exp_q.push_back(b);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic waitBitIdx(input int idx, input int budget, input string tag);
    int n = 0;
    while (mon_bit_idx != idx && n < budget) begin
      tick();
      n++;
    end
    if (mon_bit_idx != idx) checkOutput(tag, mon_bit_idx, idx);
  endtask

  task automatic waitDrain(input int budget, input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    checkOutput(tag, exp_q.size(), 0);
  endtask

  task automatic measureFrame(input logic [7:0] b, input logic [10:0] exp_frame);
    int base = frames_done;
    int n = 0;
    applyStimulus(b);
    checkOutput("start_latency_push_cycle", busy, 1'b0);
    tick();
    checkOutput("start_latency_high", busy, 1'b1);
    while (busy && n < 500) begin
      n++;
      tick();
    end
    checkOutput("busy_length", n, 22 * CLK_DIV + GAP_DIV);
    checkOutput("frame_count", frames_done, base + 1);
    checkOutput("frame_bits", last_frame, exp_frame);
    checkOutput("idle_clk", ps2_clk, 1'b1);
    checkOutput("idle_data", ps2_data, 1'b1);
  endtask

  // Line monitor: decodes frames on falling ps2_clk and checks phase lengths and data stability.
  always @(negedge clk_sys) begin
    logic [7:0] exp_b;
    if (reset) begin
      prev_clk    = 1'b1;
      hi_run      = 1000;
      lo_run      = 0;
      mon_bit_idx = 0;
    end else begin
      if (ps2_clk == 1'b0) begin
        if (prev_clk) begin
          if (mon_bit_idx == 0 || mon_bit_idx == 11 || hi_run > CLK_DIV) begin
            checkOutput("inter_frame_gap", hi_run >= GAP_DIV + CLK_DIV, 1'b1);
            mon_bit_idx = 0;
          end else begin
            checkOutput("high_phase", hi_run, CLK_DIV);
          end
          mon_bits[mon_bit_idx] = ps2_data;
          mon_bit_idx++;
          lo_run   = 1;
          low_data = ps2_data;
          if (mon_bit_idx == 11) begin
            if (exp_q.size() == 0) begin
              checkOutput("frame_unexpected", mon_bits, 0);
            end else begin
              exp_b = exp_q.pop_front();
              checkOutput("frame", mon_bits, {1'b1, ~^exp_b, exp_b, 1'b0});
            end
            last_frame = mon_bits;
            frames_done++;
          end
        end else begin
          lo_run++;
          checkOutput("data_stable_low", ps2_data, low_data);
        end
      end else begin
        if (!prev_clk) begin
          if (inhibit && mon_bit_idx < 11 && lo_run != CLK_DIV) begin
            mon_bit_idx = 0;
          end else begin
            checkOutput("low_phase", lo_run, CLK_DIV);
          end
          hi_run = 1;
        end else begin
          hi_run++;
        end
      end
      prev_clk = ps2_clk;
    end
  end

  // Hard time limit so the run always terminates.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence with scoreboard-based checking.
  initial begin
    int base;
    int bs;

    repeat (3) tick();
    checkOutput("reset_ps2_clk", ps2_clk, 1'b1);
    checkOutput("reset_ps2_data", ps2_data, 1'b1);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_in_ready", in_ready, 1'b1);
    checkOutput("reset_overflow", overflow, 1'b0);
    reset = 1'b0;
    tick();

    $display("[TB] single frame 0x1C");
    measureFrame(8'h1C, 11'h438);

    $display("[TB] single frame 0x00");
    measureFrame(8'h00, 11'h600);

    $display("[TB] abort during bit 4 then retransmit");
    base = frames_done;
    applyStimulus(8'hA5);
    waitBitIdx(5, 200, "wait_bit4");
    inhibit = 1'b1;
    tick();
    checkOutput("abort_clk_high", ps2_clk, 1'b1);
    checkOutput("abort_data_high", ps2_data, 1'b1);
    checkOutput("abort_in_gap", busy, 1'b1);
    repeat (20) tick();
    checkOutput("abort_held_idle", busy, 1'b0);
    checkOutput("abort_no_pop", frames_done, base);
    inhibit = 1'b0;
    waitDrain(400, "abort_drain");
    checkOutput("abort_resent_once", frames_done, base + 1);
    checkOutput("abort_resent_bits", last_frame, 11'h74A);
    repeat (150) tick();
    checkOutput("abort_no_duplicate", frames_done, base + 1);

    $display("[TB] inhibit during stop bit");
    base = frames_done;
    applyStimulus(8'h3C);
    waitBitIdx(1, 200, "wait_stop_start");
    waitBitIdx(11, 200, "wait_stop_bit");
    inhibit = 1'b1;
    tick();
    checkOutput("stop_not_aborted", ps2_clk, 1'b0);
    repeat (30) tick();
    checkOutput("stop_completed", frames_done, base + 1);
    checkOutput("stop_popped", exp_q.size(), 0);
    checkOutput("stop_idle", busy, 1'b0);
    inhibit = 1'b0;
    repeat (150) tick();
    checkOutput("stop_no_retransmit", frames_done, base + 1);

    $display("[TB] fill FIFO while inhibited");
    base = frames_done;
    inhibit = 1'b1;
    for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
      checkOutput("fill_in_ready", in_ready, (i < FIFO_DEPTH) ? 1'b1 : 1'b0);
      if (i == FIFO_DEPTH) checkOutput("fill_overflow_before", overflow, 1'b0);
      applyStimulus(8'h40 + 8'(i * 7));
    end
    checkOutput("fill_overflow_after", overflow, 1'b1);
    checkOutput("fill_full", in_ready, 1'b0);
    repeat (5) tick();
    checkOutput("fill_blocked", busy, 1'b0);
    inhibit = 1'b0;
    waitDrain(3000, "fill_drain");
    checkOutput("fill_frames", frames_done, base + FIFO_DEPTH);
    checkOutput("fill_ready_again", in_ready, 1'b1);
    checkOutput("fill_overflow_sticky", overflow, 1'b1);

    $display("[TB] reset during bit 6");
    applyStimulus(8'h77);
    waitBitIdx(7, 200, "wait_bit6");
    tick();
    reset = 1'b1;
    exp_q.delete();
    tick();
    checkOutput("midreset_ps2_clk", ps2_clk, 1'b1);
    checkOutput("midreset_ps2_data", ps2_data, 1'b1);
    checkOutput("midreset_busy", busy, 1'b0);
    checkOutput("midreset_in_ready", in_ready, 1'b1);
    checkOutput("midreset_overflow", overflow, 1'b0);
    reset = 1'b0;
    base = frames_done;
    bs = 0;
    repeat (150) begin
      tick();
      if (busy) bs++;
    end
    checkOutput("midreset_fifo_empty", bs, 0);
    checkOutput("midreset_no_frame", frames_done, base);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
